// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants for the FIFO pointer/flag controller.
//   DATA_W    payload width
//   ADDR_W    RAM address width
//   DEPTH     number of RAM entries (2**ADDR_W)
//   CNT_W     occupancy counter width (holds 0..DEPTH)
//   AF_THRESH / AE_THRESH  default almost_full / almost_empty thresholds
package fifo_pkg;
  localparam int DATA_W    = 10;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int AF_THRESH = 6;
  localparam int AE_THRESH = 2;
endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: bundles the producer/consumer requests, the RAM ports and
// the status outputs of one FIFO controller.
//   slave  : the controller (takes push/pop/data_in/mem_rdata, drives the rest)
//   master : the surrounding logic (producer, consumer and the RAM)
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  push, data_in, pop, mem_rdata,
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport master (
    output push, data_in, pop, mem_rdata,
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           data_out, valid_out, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrapping pointer, advances by one when en is high.
//   clk   rising-edge clock
//   reset asynchronous, active-low; clears the pointer to 0
//   en    advance request
//   ptr   current pointer value
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_d, ptr_q;

  // Natural modulo-2**W wrap of the adder gives the 7->0 rollover.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller driving an external synchronous
// dual-port RAM as a FIFO.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    fifo_ctrl_if.slave: push/data_in/pop requests, RAM write/read
//          ports, data_out/valid_out, count, full/empty, almost flags,
//          overflow/underflow pulses.
// The RAM is registered-read and read-before-write, so a simultaneous
// push+pop on a full FIFO (waddr == raddr) returns the old word.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int AF_THRESH = fifo_pkg::AF_THRESH,
  parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);
  localparam int CNT_BITS   = ADDR_W + 1;
  localparam int FIFO_DEPTH = 1 << ADDR_W;

  logic [CNT_BITS-1:0] count_d, count_q;
  logic                valid_out_d, valid_out_q;
  logic                overflow_d, overflow_q;
  logic                underflow_d, underflow_q;
  logic [ADDR_W-1:0]   wptr, rptr;
  logic                full, empty;
  logic                push_ok, pop_ok;

  assign full  = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  // Both strobes are held off while reset is asserted.
  assign push_ok = reset & bus.push & (~full | bus.pop);
  assign pop_ok  = reset & bus.pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
    valid_out_d = pop_ok;
    overflow_d  = bus.push & full & ~bus.pop;
    underflow_d = bus.pop & empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ptr #(.W(ADDR_W)) u_wptr (.clk(clk), .reset(reset), .en(push_ok), .ptr(wptr));
  fifo_ptr #(.W(ADDR_W)) u_rptr (.clk(clk), .reset(reset), .en(pop_ok),  .ptr(rptr));

  assign bus.mem_we       = push_ok;
  assign bus.mem_waddr    = wptr;
  assign bus.mem_wdata    = bus.data_in;
  assign bus.mem_re       = pop_ok;
  assign bus.mem_raddr    = rptr;
  assign bus.data_out     = bus.mem_rdata;
  assign bus.valid_out    = valid_out_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_BITS'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_BITS'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic reset;

  fifo_ctrl_if #(.DATA_W(10), .ADDR_W(3)) bus ();

  fifo_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // 8 x 10 synchronous RAM: registered read, 0 when not read, read-before-write.
  logic [9:0] ram [8];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_re ? ram[bus.mem_raddr] : 10'h000;
  end

  int total = 0;
  int passed = 0;
  logic [9:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every valid_out beat must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && bus.valid_out) begin
      if (exp_q.size() == 0) check("unexpected_valid_out", 1, 0);
      else check("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
    end
  end

  task automatic drive(input logic p, input logic [9:0] d, input logic q);
    bus.push = p; bus.data_in = d; bus.pop = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 10'h000;
  endtask

  task automatic pop_expect(input logic [9:0] w);
    drive(1'b0, 10'h000, 1'b1);
    check("pop_mem_re", int'(bus.mem_re), 1);
    exp_q.push_back(w);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 10'h3FF;
    #2;
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_almost_empty", int'(bus.almost_empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_almost_full", int'(bus.almost_full), 0);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_mem_re", int'(bus.mem_re), 0);
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = 10'h000;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Fill 0x001..0x008
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(i + 1), 1'b0);
      check("fill_mem_we", int'(bus.mem_we), 1);
      check("fill_mem_waddr", int'(bus.mem_waddr), i);
      tick();
      check("fill_count", int'(bus.count), i + 1);
      check("fill_almost_full", int'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
      check("fill_full", int'(bus.full), (i == 7) ? 1 : 0);
      check("fill_empty", int'(bus.empty), 0);
    end

    // Drain: data returns in order, one cycle after each pop
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 10'h000, 1'b1);
      check("drain_mem_raddr", int'(bus.mem_raddr), i);
      exp_q.push_back(10'(i + 1));
      tick();
      check("drain_valid_out", int'(bus.valid_out), 1);
      check("drain_count", int'(bus.count), 7 - i);
      check("drain_almost_empty", int'(bus.almost_empty), (7 - i <= 2) ? 1 : 0);
      check("drain_empty", int'(bus.empty), (i == 7) ? 1 : 0);
    end

    // Overflow: push while full without pop is dropped
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(i + 1), 1'b0); tick();
    end
    drive(1'b1, 10'h3FF, 1'b0);
    check("ovf_mem_we", int'(bus.mem_we), 0);
    tick();
    check("ovf_pulse", int'(bus.overflow), 1);
    check("ovf_count", int'(bus.count), 8);
    tick();
    check("ovf_pulse_end", int'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) pop_expect(10'(i + 1));
    check("ovf_drained_empty", int'(bus.empty), 1);

    // Underflow: pop alone, then push+pop while empty
    drive(1'b0, 10'h000, 1'b1);
    check("udf_mem_re", int'(bus.mem_re), 0);
    tick();
    check("udf_pulse1", int'(bus.underflow), 1);
    check("udf_valid1", int'(bus.valid_out), 0);
    check("udf_count1", int'(bus.count), 0);
    drive(1'b1, 10'h2AA, 1'b1);
    check("udf_pp_mem_we", int'(bus.mem_we), 1);
    check("udf_pp_mem_re", int'(bus.mem_re), 0);
    tick();
    check("udf_pulse2", int'(bus.underflow), 1);
    check("udf_valid2", int'(bus.valid_out), 0);
    check("udf_count2", int'(bus.count), 1);
    pop_expect(10'h2AA);
    check("udf_underflow_clear", int'(bus.underflow), 0);
    check("udf_count3", int'(bus.count), 0);

    // Full with 10 cycles of simultaneous push+pop; pointers start at 1
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(10'h011 + i), 1'b0); tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 10'(10'h101 + i), 1'b1);
      check("pp_mem_we", int'(bus.mem_we), 1);
      check("pp_mem_re", int'(bus.mem_re), 1);
      check("pp_waddr", int'(bus.mem_waddr), (1 + i) % 8);
      check("pp_raddr", int'(bus.mem_raddr), (1 + i) % 8);
      exp_q.push_back((i < 8) ? 10'(10'h011 + i) : 10'(10'h101 + i - 8));
      tick();
      check("pp_count", int'(bus.count), 8);
      check("pp_full", int'(bus.full), 1);
    end
    for (int i = 0; i < 8; i++) pop_expect(10'(10'h103 + i));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'(10'h0A1 + i), 1'b0); tick();
    end
    check("pre_rst_count", int'(bus.count), 5);
    #2 reset = 1'b0;
    #1;
    check("arst_count", int'(bus.count), 0);
    check("arst_empty", int'(bus.empty), 1);
    check("arst_valid_out", int'(bus.valid_out), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 10'h155, 1'b0);
    check("post_rst_waddr", int'(bus.mem_waddr), 0);
    tick();
    pop_expect(10'h155);
    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller that drives an external 8-entry × 10-bit synchronous dual-port RAM as a FIFO for transaction-layer buffering. It accepts push/pop requests from the producer and consumer sides and generates the RAM write/read ports. It returns read data with a registered valid strobe and publishes fill level, full/empty, threshold and error flags. One instance sits in front of each buffer RAM in the transaction-layer datapath.

## Interface
Parameters:
- DATA_W, 10, payload width
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W = 8
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- push  in  1  write request
- data_in  in  DATA_W  write payload
- pop  in  1  read request
- mem_we  out  1  RAM write enable
- mem_waddr  out  ADDR_W  RAM write address
- mem_wdata  out  DATA_W  RAM write data (= data_in)
- mem_re  out  1  RAM read enable
- mem_raddr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM registered read data; 0 when not read
- data_out  out  DATA_W  = mem_rdata
- valid_out  out  1  data_out carries a popped word
- count  out  ADDR_W+1  occupancy, 0..8
- full, empty, almost_full, almost_empty  out  1  status flags
- overflow, underflow  out  1  one-cycle error pulses

## Operation
- State: wptr, rptr (ADDR_W bits each, wrap 7->0), count (ADDR_W+1 bits), valid_out, overflow, underflow.
- The flags are decoded from registered count: full = (count==8), empty = (count==0).
- push_ok = push & (~full | pop). pop_ok = pop & ~empty.
- mem_we = push_ok; mem_waddr = wptr. mem_re = pop_ok; mem_raddr = rptr. All four are combinational from inputs and registered state.
- On push_ok: wptr <= wptr+1. On pop_ok: rptr <= rptr+1.
- Count update: +1 for push_ok only, −1 for pop_ok only, unchanged for both or neither.
- Full with push+pop: both are accepted and waddr == raddr. The RAM returns the old word (read-before-write), which is the required behaviour.
- Empty with push+pop: push is accepted, pop is rejected, and underflow pulses.
- Push while full without pop: the word is dropped, mem_we = 0, overflow pulses for 1 cycle, and state is unchanged.
- Pop while empty: mem_re = 0, underflow pulses for 1 cycle, and valid_out = 0 next cycle.
- RAM contents are never cleared; only the pointers reset.

## Timing
- Reset (asynchronous, immediate): wptr = rptr = 0, count = 0, valid_out = 0, overflow = underflow = 0.
  - Outputs during reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, mem_we = mem_re = 0.
- Reset asserted mid-operation: all buffered words are lost. The first push after release writes address 0.
- Write: the word pushed at edge N is poppable from cycle N+1. empty deasserts after edge N.
- Read latency is 1 cycle: pop_ok in cycle N gives data_out and valid_out = 1 in cycle N+1.
- valid_out is registered from pop_ok.
- Back-to-back pops stream one word per cycle.
- overflow and underflow are registered and assert in the cycle after the offending request.
- Flags change only on clock edges, apart from asynchronous reset.

## Structure
- Shared package fifo_pkg: DATA_W, ADDR_W, DEPTH (8), CNT_W (ADDR_W+1), default thresholds.
- No sub-module is required.
- The pointer increment is repeated twice. An optional small sub-module, fifo_ptr (wrapping ADDR_W-bit counter with enable and async active-low reset), may be factored out.
- The RAM is instantiated beside this block, not inside it.

## Test plan
- Reset, then push 0x001..0x008 on 8 consecutive cycles:
  - almost_full rises after the 6th, full and count = 8 after the 8th.
  - mem_waddr steps 0..7.
- From full, pop 8 times:
  - data_out = 0x001..0x008, each with valid_out one cycle after its pop.
  - almost_empty at count = 2, empty after the last pop.
- Full, push 0x3FF without pop: mem_we = 0, overflow = 1 for one cycle, count stays 8, the next pop returns 0x001.
- Empty, pop alone, then push+pop together:
  - underflow pulses both times, valid_out stays 0.
  - After the second, count = 1, and the next pop returns the pushed word.
- Full, 10 cycles of simultaneous push/pop:
  - count stays 8, pointers wrap 7->0.
  - data_out returns the oldest word each cycle, in order.
- Push 5 words, then assert reset between clock edges:
  - count = 0, empty = 1, valid_out = 0 immediately.
  - After release, push 0x155 then pop: data_out = 0x155.
